pipe_sequencer: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Combines four inputs: load-use bubble request from the forwarding/hazard unit, taken-branch redirect from EX, a multi-cycle mul/div busy interlock, and syscall-halt drain/resume.
- Drives per-stage enable/clear for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps cycle, stall and flush statistics counters.

---
 rtl/pipe_sequencer.sv | 152 +++++++++++++++
 tb/tb_pipe_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// mul/div interlock and syscall halt drain/resume, plus statistics counters.
module pipe_sequencer #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble,
    input  logic             branch_taken,
    input  logic             md_start_ex,
    input  logic             md_use_id,
    input  logic             halt_id,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             md_busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] MD_LAT_V = 4'(MD_LAT);

    state_t           state_reg, state_next;
    logic [1:0]       dc_reg, dc_next;
    logic [3:0]       mdc_reg;
    logic [CNT_W-1:0] cycle_cnt_reg, stall_cnt_reg, flush_cnt_reg;
    logic             stall_evt, flush_evt;
    logic             md_stall;

    assign md_busy  = (mdc_reg != 4'd0);
    assign md_stall = md_use_id & md_busy;

    always_comb begin
        state_next = state_reg;
        dc_next    = dc_reg;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_clr   = 1'b0;
        idex_en    = 1'b1;
        idex_clr   = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        halted     = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;

        unique case (state_reg)
            RUN: begin
                // A taken branch squashes ID, so anything ID asked for is wrong-path.
                if (branch_taken) begin
                    ifid_clr  = 1'b1;
                    idex_clr  = 1'b1;
                    flush_evt = 1'b1;
                end else if (bubble || md_stall) begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_clr  = 1'b1;
                    stall_evt = 1'b1;
                end else if (halt_id) begin
                    pc_en      = 1'b0;
                    ifid_clr   = 1'b1;
                    dc_next    = 2'd2;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                pc_en    = 1'b0;
                ifid_clr = 1'b1;
                if (dc_reg != 2'd0) begin
                    dc_next = dc_reg - 2'd1;
                end else begin
                    state_next = HALT;
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halted   = 1'b1;
                if (go) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (rst) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            ifid_clr  = 1'b0;
            idex_en   = 1'b0;
            idex_clr  = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            halted    = 1'b0;
            stall_evt = 1'b0;
            flush_evt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            dc_reg        <= 2'd0;
            mdc_reg       <= 4'd0;
            cycle_cnt_reg <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            dc_reg    <= dc_next;
            // A start while busy simply restarts the countdown.
            if (md_start_ex) begin
                mdc_reg <= MD_LAT_V;
            end else if (mdc_reg != 4'd0) begin
                mdc_reg <= mdc_reg - 4'd1;
            end
            if (state_reg != HALT) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            if (stall_evt) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flush_evt) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: directed scenarios then random traffic,
// checked against a timeline-based reference model.
module tb_pipe_sequencer;

    localparam int MD_LAT = 4;
    localparam int CW     = 8;   // narrow counters so cycle_cnt wraps within the run

    logic          clk = 1'b0;
    logic          rst, bubble, branch_taken, md_start_ex, md_use_id, halt_id, go;
    logic          pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en;
    logic          md_busy, halted;
    logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_sequencer #(.MD_LAT(MD_LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bubble(bubble), .branch_taken(branch_taken),
        .md_start_ex(md_start_ex), .md_use_id(md_use_id), .halt_id(halt_id), .go(go),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_en(idex_en),
        .idex_clr(idex_clr), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .md_busy(md_busy), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [8:0]    ctrl;   // pc,ifid_en,ifid_clr,idex_en,idex_clr,exmem,memwb,md_busy,halted
        logic [CW-1:0] cyc;
        logic [CW-1:0] stl;
        logic [CW-1:0] fl;
        logic [6:0]    stim;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: absolute-time bookkeeping rather than a state machine.
    int            t          = 0;
    int            md_until   = -1;  // last cycle at which a mul/div result is still pending
    int            halt_time  = -1;  // cycle at which the pending halt becomes visible
    bit            halted_m   = 1'b0;
    logic [CW-1:0] cyc_m = '0, stl_m = '0, fl_m = '0;

    task automatic cyc(input bit r, input bit b, input bit br, input bit ms,
                       input bit mu, input bit h, input bit g);
        exp_t e;
        bit   busy, stall, draining;
        @(posedge clk);
        #1;
        rst = r; bubble = b; branch_taken = br; md_start_ex = ms;
        md_use_id = mu; halt_id = h; go = g;

        busy     = (t <= md_until);
        stall    = b || (mu && busy);
        draining = (halt_time >= 0);
        e.stim   = {r, b, br, ms, mu, h, g};
        e.cyc    = cyc_m;
        e.stl    = stl_m;
        e.fl     = fl_m;
        if (r)             e.ctrl = {7'b0000000, busy, 1'b0};
        else if (halted_m) e.ctrl = {7'b0000000, busy, 1'b1};
        else if (draining) e.ctrl = {7'b0111011, busy, 1'b0};
        else if (br)       e.ctrl = {7'b1111111, busy, 1'b0};
        else if (stall)    e.ctrl = {7'b0001111, busy, 1'b0};
        else if (h)        e.ctrl = {7'b0111011, busy, 1'b0};
        else               e.ctrl = {7'b1101011, busy, 1'b0};
        exp_q.push_back(e);

        if (r) begin
            md_until = -1; halt_time = -1; halted_m = 1'b0;
            cyc_m = '0; stl_m = '0; fl_m = '0;
        end else begin
            if (!halted_m) cyc_m = cyc_m + 1'b1;
            if (halted_m) begin
                if (g) halted_m = 1'b0;
            end else if (!draining) begin
                if (br)         fl_m = fl_m + 1'b1;
                else if (stall) stl_m = stl_m + 1'b1;
                else if (h)     halt_time = t + 4;
            end
            if (halt_time == t + 1) begin
                halted_m  = 1'b1;
                halt_time = -1;
            end
            if (ms) md_until = t + MD_LAT;
        end
        t++;
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en,
                       md_busy, halted};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl stim=%b got=%b exp=%b", e.stim, act, e.ctrl);
                end
                checks++;
                if ({cycle_cnt, stall_cnt, flush_cnt} !== {e.cyc, e.stl, e.fl}) begin
                    errors++;
                    $display("FAIL counters stim=%b got cyc=%0d stl=%0d fl=%0d exp cyc=%0d stl=%0d fl=%0d",
                             e.stim, cycle_cnt, stall_cnt, flush_cnt, e.cyc, e.stl, e.fl);
                end
                $display("txn stim=%b ctrl=%b cyc=%0d stl=%0d fl=%0d",
                         e.stim, act, cycle_cnt, stall_cnt, flush_cnt);
            end
        end
    end

    initial begin
        rst = 1'b1; bubble = 1'b0; branch_taken = 1'b0; md_start_ex = 1'b0;
        md_use_id = 1'b0; halt_id = 1'b0; go = 1'b0;
        // reset held two cycles, then idle
        cyc(1,0,0,0,0,0,0); cyc(1,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
        // load-use single bubble
        cyc(0,1,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
        // branch and bubble together
        cyc(0,1,1,0,0,0,0); cyc(0,0,0,0,0,0,0);
        // mul/div interlock
        cyc(0,0,0,1,0,0,0);
        for (int i = 0; i < 6; i++) cyc(0,0,0,0,1,0,0);
        // halt, drain, hold, resume
        cyc(0,0,0,0,0,1,0);
        for (int i = 0; i < 13; i++) cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,1); cyc(0,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
        // go outside HALT ignored; squashed halt
        cyc(0,0,0,0,0,0,1);
        cyc(0,0,1,0,0,1,0); cyc(0,0,0,0,0,0,0);
        // reset in mid-drain and mid-stall
        cyc(0,0,0,0,0,1,0); cyc(0,0,0,0,0,0,0); cyc(1,0,0,0,0,0,0); cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,1,1,0,0); cyc(0,0,0,0,1,0,0); cyc(1,0,0,0,1,0,0); cyc(0,0,0,0,1,0,0);
        // random traffic, long enough to wrap the narrow cycle counter
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 15),
                ($urandom_range(99) < 15), ($urandom_range(99) < 15),
                ($urandom_range(99) < 40), ($urandom_range(99) < 6),
                ($urandom_range(99) < 20));
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
